// File: rtl/gcd_feeder.sv
// gcd_feeder: operand FIFO and one-job-at-a-time sequencer wrapped around the subtractive GCD engine.
// Define GCD_FEEDER_STATS_EN to build the completed-result counter driven onto job_count.
module gcd_feeder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_bypass,
    output logic [15:0] job_count,
    output logic        eng_go,
    output logic [7:0]  eng_a,
    output logic [7:0]  eng_b,
    output logic        eng_rst,
    input  logic        eng_done,
    input  logic [7:0]  eng_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE1, CLEAR, OUT} state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    fifo_a [DEPTH];
    logic [7:0]    fifo_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic          head_zero;
    logic [7:0]    op_a;
    logic [7:0]    op_b;

    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign head_a     = fifo_a[rd_ptr];
    assign head_b     = fifo_b[rd_ptr];
    assign head_zero  = (head_a == 8'd0) || (head_b == 8'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    // Occupancy is registered, so a freshly pushed entry is only poppable next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = head_zero ? OUT : LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (eng_done) begin
                    state_next = DONE1;
                end
            end
            DONE1: state_next = CLEAR;
            CLEAR: state_next = OUT;
            OUT: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Engine strobes come from the next state so they are flop outputs aligned with LAUNCH/CLEAR;
    // the engine is held in reset for as long as we are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            res_data   <= '0;
            res_bypass <= 1'b0;
            eng_go     <= 1'b0;
            eng_rst    <= 1'b1;
        end else begin
            eng_go  <= (state_next == LAUNCH);
            eng_rst <= (state_next == CLEAR);
            if (pop) begin
                op_a <= head_a;
                op_b <= head_b;
            end
            if (pop && head_zero) begin
                res_data   <= head_a | head_b;
                res_bypass <= 1'b1;
            end else if (state == DONE1) begin
                res_data   <= eng_out;
                res_bypass <= 1'b0;
            end
        end
    end

    assign res_valid = (state == OUT);
    assign eng_a     = op_a;
    assign eng_b     = op_b;

`ifdef GCD_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_count <= '0;
        end else if (res_valid && res_ready) begin
            job_count <= job_count + 16'd1;
        end
    end
`else
    assign job_count = '0;
`endif

endmodule

// File: tb/tb_gcd_feeder.sv
// Self-checking bench for gcd_feeder: behavioural top_gcd engine, in-order result scoreboard,
// a directed vector table, multi-cycle corner sequences and a randomized stream.
`timescale 1ns/1ps
module tb_gcd_feeder;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_bypass;
    logic [15:0] job_count;
    logic        eng_go;
    logic [7:0]  eng_a;
    logic [7:0]  eng_b;
    logic        eng_rst;
    logic        eng_done;
    logic [7:0]  eng_out;

    gcd_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_bypass(res_bypass), .job_count(job_count),
        .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b), .eng_rst(eng_rst),
        .eng_done(eng_done), .eng_out(eng_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sub_steps(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x = a;
        logic [7:0] y = b;
        int n = 0;
        if (x == 0 || y == 0) return 0;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] sub_result(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x = a;
        logic [7:0] y = b;
        if (x == 0 || y == 0) return 8'd0;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // Engine: samples go, spends 3 cycles plus 3 per subtraction, raises done, then its
    // output register becomes valid one cycle later and holds until rst.
    int         m_left;
    logic       m_busy;
    logic [7:0] m_res;
    always @(posedge clk) begin
        if (eng_rst) begin
            m_busy   <= 1'b0;
            m_left   <= 0;
            eng_done <= 1'b0;
            eng_out  <= 8'h00;
        end else if (!m_busy) begin
            if (eng_go) begin
                m_busy  <= 1'b1;
                m_left  <= 3 + 3 * sub_steps(eng_a, eng_b);
                m_res   <= sub_result(eng_a, eng_b);
                eng_out <= 8'hEE;
            end
        end else if (!eng_done) begin
            if (m_left == 1) eng_done <= 1'b1;
            m_left <= m_left - 1;
        end else begin
            eng_out <= m_res;
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic       bypass;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic       bypass;
        int         latency;
    } vec_t;

    int   vectors = 0;
    int   errors  = 0;
    res_t exp_q[$];
    int   res_count = 0;
    int   go_cycles = 0;
    int   rst_cycles = 0;
    logic s_handshake, s_res_hs, s_res_valid, s_in_ready, s_eng_rst;
    logic [7:0] s_res_data;
    logic s_res_bypass;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_go = 1'b0;
    res_t prev_res;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_job_count();
`ifdef GCD_FEEDER_STATS_EN
        return 16'(res_count);
`else
        return 16'd0;
`endif
    endfunction

    // Negedge monitor: scoreboard pushes on accepted operands, pops on accepted results.
    task automatic sample();
        res_t r;
        s_in_ready   = in_ready;
        s_res_valid  = res_valid;
        s_res_data   = res_data;
        s_res_bypass = res_bypass;
        s_eng_rst    = eng_rst;
        s_handshake  = rst_n && in_valid && in_ready;
        s_res_hs     = rst_n && res_valid && res_ready;
        if (!rst_n) begin
            exp_q.delete();
            res_count  = 0;
            prev_valid = 1'b0;
            prev_go    = 1'b0;
            return;
        end
        if (s_handshake) exp_q.push_back('{ref_gcd(in_a, in_b), (in_a == 0) || (in_b == 0)});
        if (eng_go) begin
            go_cycles++;
            checkOutput("eng_go single cycle", 32'(prev_go), 32'd0);
        end
        if (eng_rst) rst_cycles++;
        if (prev_valid && !prev_ready) begin
            checkOutput("hold res_valid", 32'(res_valid), 32'd1);
            checkOutput("hold result", 32'({res_data, res_bypass}), 32'(prev_res));
        end
        if (s_res_hs) begin
            res_count++;
            checkOutput("result expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                checkOutput("sb data", 32'(res_data), 32'(r.data));
                checkOutput("sb bypass", 32'(res_bypass), 32'(r.bypass));
            end
        end
        prev_valid = res_valid;
        prev_ready = res_ready;
        prev_go    = eng_go;
        prev_res   = '{res_data, res_bypass};
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            ok = s_handshake;
        end
        in_valid = 1'b0;
        checkOutput("push accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_result(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (s_res_valid) begin
                lat = i;
                return;
            end
        end
        checkOutput("result timeout", 32'(s_res_valid), 32'd1);
    endtask

    task automatic drain(input int budget);
        res_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        checkOutput("drained", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs[9];
    logic exp_rdy[7];

    initial begin
        int lat;
        int accepted;
        int base;
        int idx;
        bit offering;

        vecs[0] = '{8'd48,  8'd18, 8'd6,  1'b0, 21};
        vecs[1] = '{8'd9,   8'd9,  8'd9,  1'b0, 9};
        vecs[2] = '{8'd0,   8'd35, 8'd35, 1'b1, 2};
        vecs[3] = '{8'd12,  8'd0,  8'd12, 1'b1, 2};
        vecs[4] = '{8'd0,   8'd0,  8'd0,  1'b1, 2};
        vecs[5] = '{8'd21,  8'd14, 8'd7,  1'b0, 15};
        vecs[6] = '{8'd100, 8'd75, 8'd25, 1'b0, 18};
        vecs[7] = '{8'd1,   8'd1,  8'd1,  1'b0, 9};
        vecs[8] = '{8'd255, 8'd1,  8'd1,  1'b0, 771};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset res_data", 32'(res_data), 32'd0);
        checkOutput("reset res_bypass", 32'(res_bypass), 32'd0);
        checkOutput("reset eng_go", 32'(eng_go), 32'd0);
        checkOutput("reset eng_rst", 32'(eng_rst), 32'd1);
        checkOutput("reset eng_a/b", 32'({eng_a, eng_b}), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset job_count", 32'(job_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] directed vector table");
        res_ready = 1'b1;
        foreach (vecs[i]) begin
            go_cycles  = 0;
            rst_cycles = 0;
            applyStimulus(vecs[i].a, vecs[i].b);
            wait_result(1000, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].latency));
            checkOutput($sformatf("vec%0d data", i), 32'(s_res_data), 32'(vecs[i].data));
            checkOutput($sformatf("vec%0d bypass", i), 32'(s_res_bypass), 32'(vecs[i].bypass));
            tick();
            checkOutput($sformatf("vec%0d go pulses", i), 32'(go_cycles), vecs[i].bypass ? 32'd0 : 32'd1);
            checkOutput($sformatf("vec%0d eng_rst cycles", i), 32'(rst_cycles), vecs[i].bypass ? 32'd0 : 32'd1);
        end
        checkOutput("job_count after table", 32'(job_count), 32'(exp_job_count()));

        $display("[TB] fifo fill with consumer stalled");
        res_ready = 1'b0;
        accepted  = 0;
        base      = res_count;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom_range(1, 30));
            in_b     = 8'($urandom_range(1, 30));
            tick();
            checkOutput($sformatf("offer%0d in_ready", i), 32'(s_in_ready), 32'(exp_rdy[i]));
            if (s_handshake) accepted++;
        end
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (s_handshake) accepted++;
        end
        in_valid = 1'b0;
        checkOutput("accepted while stalled", 32'(accepted), 32'd5);
        checkOutput("stalled result pending", 32'(s_res_valid), 32'd1);
        drain(5000);
        checkOutput("fill results drained", 32'(res_count - base), 32'd5);

        $display("[TB] result hold");
        res_ready = 1'b0;
        applyStimulus(8'd21, 8'd14);
        applyStimulus(8'd8, 8'd12);
        wait_result(200, lat);
        go_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("held res_valid", 32'(s_res_valid), 32'd1);
            checkOutput("held res_data", 32'(s_res_data), 32'd7);
        end
        checkOutput("no pop while held", 32'(go_cycles), 32'd0);
        checkOutput("held fifo not full", 32'(s_in_ready), 32'd1);
        drain(500);

        $display("[TB] reset mid-job");
        res_ready = 1'b1;
        applyStimulus(8'd255, 8'd1);
        applyStimulus(8'd6, 8'd4);
        applyStimulus(8'd10, 8'd5);
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst eng_rst", 32'(eng_rst), 32'd1);
        checkOutput("rst eng_go", 32'(eng_go), 32'd0);
        checkOutput("rst eng_a", 32'(eng_a), 32'd0);
        checkOutput("rst job_count", 32'(job_count), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("eng_rst held to first edge", 32'(s_eng_rst), 32'd1);
        checkOutput("eng_rst released", 32'(eng_rst), 32'd0);
        go_cycles = 0;
        repeat (10) tick();
        checkOutput("fifo empty after reset", 32'(go_cycles + res_count), 32'd0);
        applyStimulus(8'd21, 8'd14);
        wait_result(200, lat);
        checkOutput("post-reset data", 32'(s_res_data), 32'd7);
        repeat (900) tick();
        checkOutput("single post-reset result", 32'(res_count), 32'd1);
        checkOutput("job_count after reset", 32'(job_count), 32'(exp_job_count()));

        $display("[TB] randomized stream");
        idx      = 0;
        offering = 1'b0;
        for (int cyc = 0; cyc < 60000 && !(idx == 40 && exp_q.size() == 0); cyc++) begin
            if (!offering && idx < 40 && $urandom_range(0, 9) < 7) begin
                in_a     = ($urandom_range(0, 99) < 15) ? 8'd0 : 8'($urandom_range(1, 255));
                in_b     = ($urandom_range(0, 99) < 15) ? 8'd0 : 8'($urandom_range(1, 255));
                in_valid = 1'b1;
                offering = 1'b1;
            end
            res_ready = ($urandom_range(0, 9) < 6);
            tick();
            if (s_handshake) begin
                offering = 1'b0;
                in_valid = 1'b0;
                idx++;
            end
        end
        in_valid = 1'b0;
        checkOutput("random all issued", 32'(idx), 32'd40);
        drain(2000);
        checkOutput("job_count final", 32'(job_count), 32'(exp_job_count()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
